// File: rtl/serial_addsub_nib_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
//   NIBBLE_W   : width of the carry-lookahead slice
//   ST_*       : FSM state encodings (legacy-compatible constants)
//   idx_width  : width of the nibble index counter for a given nibble count
package serial_addsub_nib_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A single-nibble datapath would need a zero-width counter; keep at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_nib_cla.sv
// cla_04_ci: 4-bit carry-lookahead adder slice with explicit carry input.
// Ports:
//   src1[3:0]  in   addend A nibble
//   src2[3:0]  in   addend B nibble (already inverted by the caller for subtract)
//   carry_in   in   carry into bit 0
//   sum[3:0]   out  nibble sum
//   carry_out  out  carry out of bit 3
module cla_04_ci (
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] c;

    assign gen  = src1 & src2;
    assign prop = src1 ^ src2;

    // Flattened lookahead equations: every carry depends only on g/p and carry_in.
    assign c[0] = carry_in;
    assign c[1] = gen[0] | (prop[0] & carry_in);
    assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_in);
    assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & carry_in);
    assign c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0])
                | (prop[3] & prop[2] & prop[1] & prop[0] & carry_in);

    assign sum       = prop ^ c[3:0];
    assign carry_out = c[4];

endmodule

// File: rtl/serial_addsub_nib.sv
// serial_addsub_nib: multi-cycle WIDTH-bit add/subtract built on one 4-bit CLA
// slice, processing one nibble per clock, LSB nibble first.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   operand bundle valid
//   in_ready   out  operands can be accepted (idle only)
//   src1       in   operand A
//   src2       in   operand B
//   sub_flag   in   0: A+B, 1: A-B
//   out_valid  out  result bundle valid
//   out_ready  in   downstream accepts result
//   result     out  sum/difference modulo 2^WIDTH
//   carry_out  out  carry out of MSB (subtract: 1 = no borrow)
//   overflow   out  two's-complement signed overflow
module serial_addsub_nib
    import serial_addsub_nib_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N        = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    result_q;
    logic                carry_q;
    logic                carry_out_q;
    logic                overflow_q;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_carry;

    assign nib_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*idx +: NIBBLE_W];

    cla_04_ci u_cla (
        .src1      (nib_a),
        .src2      (nib_b),
        .carry_in  (carry_q),
        .sum       (nib_sum),
        .carry_out (nib_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B here, inject the +1 as the first carry.
                        a_q     <= src1;
                        b_q     <= sub_flag ? ~src2 : src2;
                        carry_q <= sub_flag;
                        idx     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q[NIBBLE_W*idx +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_carry;
                    idx     <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        carry_out_q <= nib_carry;
                        // Signed overflow: like-signed operands producing an opposite-signed sum.
                        overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                                     & (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_nib.sv
module tb_serial_addsub_nib;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             sub_flag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;

    serial_addsub_nib #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .sub_flag  (sub_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one op from idle, scrambles inputs after acceptance, waits (bounded)
    // for out_valid, captures outputs and retires the result. lat counts clock
    // edges from the accept edge until out_valid is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] r, output logic co, output logic ov,
                          output int lat);
        lat = 0;
        src1 = a; src2 = b; sub_flag = s; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; src1 = ~a; src2 = ~b; sub_flag = ~s;
        while (!out_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        r = result; co = carry_out; ov = overflow;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; sub_flag = 1'b0;
        #2;
        total_cnt++;
        if ({in_ready, out_valid, carry_out, overflow} !== 4'b1000 || result !== 32'h0) begin
            $display("FAIL reset_during: rdy/vld/co/ov=%b result=%h, expected 1000 / 00000000",
                     {in_ready, out_valid, carry_out, overflow}, result);
        end else pass_cnt++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, carry_out, overflow} !== 4'b1000 || result !== 32'h0) begin
            $display("FAIL reset_after: rdy/vld/co/ov=%b result=%h, expected 1000 / 00000000",
                     {in_ready, out_valid, carry_out, overflow}, result);
        end else pass_cnt++;
    endtask

    task automatic test_add_sub();
        logic [31:0] ta [8] = '{32'h0000_0005, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h0000_0000, 32'h8000_0000, 32'h0000_0005, 32'h0000_0003};
        logic [31:0] tb [8] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000,
                                32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 32'h0000_0005};
        logic        ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] er [8] = '{32'h0000_0008, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                                32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        logic        ec [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eo [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] r;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], r, co, ov, lat);
            total_cnt++;
            if (lat !== 8) $display("FAIL latency[%0d]: got %0d cycles, expected 8", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (r !== er[i]) $display("FAIL result[%0d]: got %h, expected %h", i, r, er[i]);
            else pass_cnt++;
            total_cnt++;
            if (co !== ec[i]) $display("FAIL carry_out[%0d]: got %b, expected %b", i, co, ec[i]);
            else pass_cnt++;
            total_cnt++;
            if (ov !== eo[i]) $display("FAIL overflow[%0d]: got %b, expected %b", i, ov, eo[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        src1 = 32'h0000_00FF; src2 = 32'h0000_0001; sub_flag = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        // keep offering a different op; it must not be taken while busy
        src1 = 32'h1111_1111; src2 = 32'h2222_2222;
        while (!out_valid && cyc < 40) begin
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL bp_run_in_ready: got %b, expected 0", in_ready);
            else pass_cnt++;
            @(posedge clk); cyc++; @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({out_valid, in_ready} !== 2'b10 || result !== 32'h0000_0100 ||
                carry_out !== 1'b0 || overflow !== 1'b0) begin
                $display("FAIL bp_hold[%0d]: vld/rdy=%b result=%h co=%b ov=%b, expected 10 00000100 0 0",
                         i, {out_valid, in_ready}, result, carry_out, overflow);
            end else pass_cnt++;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: vld/rdy=%b, expected 01", {out_valid, in_ready});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [3] = '{32'h0000_0001, 32'h0000_0010, 32'h7FFF_FFFF};
        logic [31:0] tb [3] = '{32'h0000_0002, 32'h0000_0020, 32'h7FFF_FFFF};
        logic        ts [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] er [3] = '{32'h0000_0003, 32'hFFFF_FFF0, 32'hFFFF_FFFE};
        logic        ec [3] = '{1'b0, 1'b0, 1'b0};
        logic        eo [3] = '{1'b0, 1'b0, 1'b1};
        int issued = 0, collected = 0, cyc = 0, extra = 0;
        out_ready = 1'b1;
        while (collected < 3 && cyc < 200) begin
            if (out_valid) begin
                total_cnt++;
                if ({carry_out, overflow, result} !== {ec[collected], eo[collected], er[collected]})
                    $display("FAIL b2b[%0d]: co/ov/result=%b%b %h, expected %b%b %h", collected,
                             carry_out, overflow, result, ec[collected], eo[collected], er[collected]);
                else pass_cnt++;
                collected++;
                if (collected == 3) in_valid = 1'b0;
            end
            if (in_ready && issued < 3) begin
                src1 = ta[issued]; src2 = tb[issued]; sub_flag = ts[issued]; in_valid = 1'b1;
                issued++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            @(posedge clk); cyc++; @(negedge clk);
        end
        total_cnt++;
        if (collected !== 3) $display("FAIL b2b_count: got %0d results, expected 3", collected);
        else pass_cnt++;
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) extra++;
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b0;
        total_cnt++;
        if (extra !== 0) $display("FAIL b2b_extra: got %0d extra valid cycles, expected 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r;
        logic        co, ov;
        int          lat, seen = 0;
        src1 = 32'h1234_5678; src2 = 32'h1111_1111; sub_flag = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL midrst_busy: in_ready got %b, expected 0", in_ready);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, carry_out, overflow} !== 4'b1000 || result !== 32'h0)
            $display("FAIL midrst_values: rdy/vld/co/ov=%b result=%h, expected 1000 / 00000000",
                     {in_ready, out_valid, carry_out, overflow}, result);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); @(negedge clk);
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL midrst_no_valid: got %0d valid cycles, expected 0", seen);
        else pass_cnt++;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, r, co, ov, lat);
        total_cnt++;
        if ({lat == 8, co, ov, r} !== {1'b1, 1'b0, 1'b0, 32'h2345_6789})
            $display("FAIL midrst_after: lat=%0d co=%b ov=%b result=%h, expected 8 0 0 23456789",
                     lat, co, ov, r);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, beff, r, er;
        logic        s, co, ov, ec, eo;
        logic [32:0] full;
        int          lat;
        for (int i = 0; i < 300; i++) begin
            a = $urandom; b = $urandom; s = 1'(($urandom % 2));
            if (i % 10 == 0) a = {a[31], 31'h7FFF_FFFF};
            beff = s ? ~b : b;
            full = {1'b0, a} + {1'b0, beff} + {32'h0, s};
            er = full[31:0];
            ec = full[32];
            if (s) eo = (a[31] != b[31]) && (er[31] != a[31]);
            else   eo = (a[31] == b[31]) && (er[31] != a[31]);
            run_op(a, b, s, r, co, ov, lat);
            total_cnt++;
            if ({lat == 8, co, ov, r} !== {1'b1, ec, eo, er})
                $display("FAIL rand[%0d] a=%h b=%h sub=%b: lat=%0d co=%b ov=%b result=%h, expected 8 %b %b %h",
                         i, a, b, s, lat, co, ov, r, ec, eo, er);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
